// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master transmit core.
package spi_pkg;

    // Frame sequencing: LEAD gives the first data bit one tick of setup
    // before the first rising edge, TRAIL holds CS one tick after the last
    // falling edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    // Width needed to count rising edges 0..size inclusive.
    function automatic int unsigned bitcnt_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Programmable clock-enable divider: one-cycle tick every clk_count_max+1 cycles.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_SIZE = 3
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [CLK_SIZE-1:0] clk_count_max,
    output logic                tick_out
);

    logic [CLK_SIZE-1:0] count;
    logic                at_limit;

    // A compare of >= lets a lowered limit force an immediate wrap.
    always_comb begin
        at_limit = (count >= clk_count_max);
        tick_out = at_limit;
    end

    // Free-running counter that wraps whenever the limit is reached.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (at_limit) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_tx_core.sv
// SPI mode-0 master transmit core: divider, MSB-first shifter and CS demux.
module spi_tx_core
    import spi_pkg::*;
#(
    parameter int unsigned SIZE     = 40,
    parameter int unsigned CS_SIZE  = 1,
    parameter int unsigned CLK_SIZE = 3
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [SIZE-1:0]     data_in,
    input  logic [CLK_SIZE-1:0] clk_count_max,
    input  logic                send_enable_in,
    input  logic [CS_SIZE-1:0]  cs_select_in,
    output logic                sck_out,
    output logic                serial_out,
    output logic [CS_SIZE-1:0]  cs_out_n,
    output logic                busy_out
);

    localparam int unsigned CNT_W = bitcnt_width(SIZE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE);

    spi_state_t       state;
    logic [SIZE-1:0]  shreg;
    logic [CNT_W-1:0] bitcnt;
    logic             armed;
    logic             tick;

    spi_tick_gen #(
        .CLK_SIZE(CLK_SIZE)
    ) u_tick_gen (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .clk_count_max(clk_count_max),
        .tick_out     (tick)
    );

    // Frame sequencer: all pin outputs are registered here and advance on ticks,
    // except abort and re-arm which act on every clock.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state      <= IDLE;
            sck_out    <= 1'b0;
            serial_out <= 1'b0;
            cs_out_n   <= '1;
            busy_out   <= 1'b0;
            armed      <= 1'b1;
            shreg      <= '0;
            bitcnt     <= '0;
        end else begin
            if (busy_out && !send_enable_in) begin
                // Request withdrawn mid-frame: release the bus, MOSI holds.
                state    <= IDLE;
                sck_out  <= 1'b0;
                cs_out_n <= '1;
                busy_out <= 1'b0;
            end else if (tick) begin
                unique case (state)
                    IDLE: begin
                        sck_out  <= 1'b0;
                        if (send_enable_in && armed) begin
                            shreg      <= data_in;
                            serial_out <= data_in[SIZE-1];
                            cs_out_n   <= ~cs_select_in;
                            busy_out   <= 1'b1;
                            bitcnt     <= '0;
                            state      <= LEAD;
                        end
                    end
                    LEAD: begin
                        sck_out <= 1'b1;
                        bitcnt  <= CNT_W'(1);
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (!sck_out) begin
                            sck_out <= 1'b1;
                            bitcnt  <= bitcnt + 1'b1;
                        end else begin
                            sck_out <= 1'b0;
                            if (bitcnt == LAST_BIT) begin
                                state <= TRAIL;
                            end else begin
                                // Rotate rather than shift so every stored bit
                                // stays live; only the next-MSB is ever observed.
                                shreg      <= {shreg[SIZE-2:0], shreg[SIZE-1]};
                                serial_out <= shreg[SIZE-2];
                            end
                        end
                    end
                    TRAIL: begin
                        sck_out  <= 1'b0;
                        cs_out_n <= '1;
                        busy_out <= 1'b0;
                        armed    <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            // Any low request re-arms; written last so it wins over TRAIL.
            if (!send_enable_in) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_core.sv
// Directed scoreboard bench for spi_tx_core (SIZE=8, CS_SIZE=4).
module tb_spi_tx_core;

    localparam int unsigned SIZE     = 8;
    localparam int unsigned CS_SIZE  = 4;
    localparam int unsigned CLK_SIZE = 3;

    logic                clk_in;
    logic                reset_in;
    logic [SIZE-1:0]     data_in;
    logic [CLK_SIZE-1:0] clk_count_max;
    logic                send_enable_in;
    logic [CS_SIZE-1:0]  cs_select_in;
    logic                sck_out;
    logic                serial_out;
    logic [CS_SIZE-1:0]  cs_out_n;
    logic                busy_out;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor state
    logic           exp_q[$];
    int             cyc        = 0;
    int             rise_cnt   = 0;
    int             last_rise  = 0;
    int             period     = 0;
    int             cs_low     = 0;
    logic [3:0]     cs_seen    = '1;
    logic           prev_sck   = 1'b0;

    spi_tx_core #(
        .SIZE    (SIZE),
        .CS_SIZE (CS_SIZE),
        .CLK_SIZE(CLK_SIZE)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .data_in       (data_in),
        .clk_count_max (clk_count_max),
        .send_enable_in(send_enable_in),
        .cs_select_in  (cs_select_in),
        .sck_out       (sck_out),
        .serial_out    (serial_out),
        .cs_out_n      (cs_out_n),
        .busy_out      (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    // Sample on the falling edge: detect sck rises, pop expected MOSI bits,
    // measure sck period and CS-low duration.
    always @(negedge clk_in) begin
        if (sck_out === 1'b1 && prev_sck === 1'b0) begin
            rise_cnt++;
            if (rise_cnt > 1) period = cyc - last_rise;
            last_rise = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL mosi_extra edge=%0d observed=%0b required=no_edge", rise_cnt, serial_out);
            end else begin
                logic e;
                e = exp_q.pop_front();
                assert (serial_out === e) else begin
                    miscompares++;
                    $error("FAIL mosi_bit edge=%0d observed=%0b required=%0b", rise_cnt, serial_out, e);
                end
            end
        end
        prev_sck = sck_out;
        if (cs_out_n !== '1) begin
            cs_low++;
            cs_seen = cs_out_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic clear_stats();
        rise_cnt = 0;
        period   = 0;
        cs_low   = 0;
        cs_seen  = '1;
    endtask

    task automatic push_word(input logic [SIZE-1:0] w);
        for (int i = SIZE - 1; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic wait_busy(input logic level, input int limit, input string tag);
        int n;
        n = 0;
        while (busy_out !== level && n < limit) begin
            step(1);
            n++;
        end
        check(tag, 32'(busy_out), 32'(level));
    endtask

    task automatic wait_rises(input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (rise_cnt < target && n < limit) begin
            step(1);
            n++;
        end
        check(tag, rise_cnt, target);
    endtask

    task automatic start_frame(input logic [SIZE-1:0] d, input logic [CS_SIZE-1:0] cs,
                               input logic [CLK_SIZE-1:0] mx);
        clear_stats();
        push_word(d);
        data_in        = d;
        cs_select_in   = cs;
        clk_count_max  = mx;
        send_enable_in = 1'b1;
    endtask

    initial begin
        reset_in       = 1'b1;
        send_enable_in = 1'b0;
        data_in        = '0;
        clk_count_max  = 3'd1;
        cs_select_in   = '0;

        // Reset state
        step(3);
        check("rst_sck",  32'(sck_out),    32'd0);
        check("rst_mosi", 32'(serial_out), 32'd0);
        check("rst_cs",   32'(cs_out_n),   32'hF);
        check("rst_busy", 32'(busy_out),   32'd0);
        reset_in = 1'b0;
        step(1);

        // Frame 1: 0xA5, divider 1, CS0, request held high
        start_frame(8'hA5, 4'b0001, 3'd1);
        wait_busy(1'b1, 20, "f1_start");
        wait_busy(1'b0, 200, "f1_end");
        check("f1_cs_low", cs_low,   34);
        check("f1_rises",  rise_cnt, 8);
        check("f1_period", period,   4);
        check("f1_cs_sel", 32'(cs_seen), 32'hE);
        check("f1_queue",  exp_q.size(), 0);
        step(40);
        check("f1_single_rises", rise_cnt, 8);
        check("f1_single_busy",  32'(busy_out), 32'd0);

        // Frame 2: drop, re-raise with 0x3C on CS2
        send_enable_in = 1'b0;
        step(2);
        start_frame(8'h3C, 4'b0100, 3'd1);
        wait_busy(1'b1, 20, "f2_start");
        wait_busy(1'b0, 200, "f2_end");
        check("f2_cs_sel", 32'(cs_seen), 32'hB);
        check("f2_cs_low", cs_low,   34);
        check("f2_rises",  rise_cnt, 8);
        check("f2_queue",  exp_q.size(), 0);

        // Frame 3: divider 0, fastest clock
        send_enable_in = 1'b0;
        step(2);
        start_frame(8'h96, 4'b0001, 3'd0);
        wait_busy(1'b1, 20, "f3_start");
        wait_busy(1'b0, 200, "f3_end");
        check("f3_cs_low", cs_low,   17);
        check("f3_period", period,   2);
        check("f3_rises",  rise_cnt, 8);
        check("f3_queue",  exp_q.size(), 0);

        // Abort after the third rising edge
        send_enable_in = 1'b0;
        step(2);
        start_frame(8'hC3, 4'b0001, 3'd1);
        wait_busy(1'b1, 20, "ab_start");
        wait_rises(3, 100, "ab_reach3");
        send_enable_in = 1'b0;
        step(1);
        check("ab_sck",  32'(sck_out),    32'd0);
        check("ab_cs",   32'(cs_out_n),   32'hF);
        check("ab_busy", 32'(busy_out),   32'd0);
        check("ab_mosi", 32'(serial_out), 32'd0);
        exp_q.delete();
        step(20);
        check("ab_no_more_rises", rise_cnt, 3);

        // Mid-frame data/select change must not alter the frame
        step(2);
        start_frame(8'h5A, 4'b0010, 3'd1);
        wait_busy(1'b1, 20, "mc_start");
        wait_rises(2, 100, "mc_reach2");
        data_in      = 8'hFF;
        cs_select_in = 4'b1111;
        wait_busy(1'b0, 200, "mc_end");
        check("mc_rises",  rise_cnt, 8);
        check("mc_cs_sel", 32'(cs_seen), 32'hD);
        check("mc_queue",  exp_q.size(), 0);

        // Empty select: frame runs with no CS asserted
        send_enable_in = 1'b0;
        step(2);
        start_frame(8'h81, 4'b0000, 3'd1);
        wait_busy(1'b1, 20, "nc_start");
        wait_busy(1'b0, 200, "nc_end");
        check("nc_cs_low", cs_low,   0);
        check("nc_rises",  rise_cnt, 8);
        check("nc_queue",  exp_q.size(), 0);

        send_enable_in = 1'b0;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_tx_core.md
Name: spi_tx_core

Overview:
SPI master transmit core. It combines three functions: a programmable clock-enable divider, a parallel-in/serial-out shifter driving MOSI, and a chip-select demultiplexer.
- One word of SIZE bits is sent MSB-first in SPI mode 0 (CPOL=0, CPHA=0) for each assertion of send_enable_in.
- It sits between the stepper-driver register logic and the SPI pins. It runs entirely in the system clock domain using enable strobes, not derived clocks.

Parameters:
SIZE, 40, bits per frame (≥2)
CS_SIZE, 1, number of chip-select lines
CLK_SIZE, 3, width of divider compare value

Ports:
clk_in  input  1  system clock; all logic on rising edge
reset_in  input  1  synchronous active-high reset
data_in  input  SIZE  word to transmit; sampled at frame start only
clk_count_max  input  CLK_SIZE  divider compare value; tick period = clk_count_max+1 clk_in cycles
send_enable_in  input  1  level request; high starts one frame; must drop before the next frame
cs_select_in  input  CS_SIZE  one-hot target mask; sampled at frame start
sck_out  output  1  SPI clock, idle low
serial_out  output  1  MOSI
cs_out_n  output  CS_SIZE  active-low chip selects
busy_out  output  1  high from CS assertion until CS release

Behaviour:
- All outputs are registered.
- Reset (reset_in=1 at a clk_in edge):
  - sck_out=0, serial_out=0, cs_out_n all 1, busy_out=0.
  - Divider count 0, state IDLE, armed=1.
- Divider:
  - Counter increments each clk_in cycle.
  - When count >= clk_count_max: tick=1 for that cycle and count wraps to 0.
  - clk_count_max=0 gives a tick every cycle.
  - Lowering clk_count_max below the current count forces a tick on the next cycle.
- State transitions and outputs take effect at the clk_in edge where tick=1, unless stated otherwise.
- IDLE:
  - sck_out=0, cs_out_n all 1.
  - On tick with send_enable_in=1 and armed=1: shreg<=data_in; serial_out<=data_in[SIZE-1]; sel<=cs_select_in; cs_out_n<=~sel; busy_out<=1; bitcnt<=0; go to LEAD.
- LEAD: next tick sets sck_out<=1, bitcnt<=1 (first rising edge), go to SHIFT.
- SHIFT: each tick toggles sck_out.
  - 0->1 tick: bitcnt++.
  - 1->0 tick: if bitcnt==SIZE go to TRAIL; else shift shreg left and serial_out<=next bit.
- TRAIL:
  - sck_out stays 0.
  - Next tick: cs_out_n<=all 1, busy_out<=0, armed<=0, go to IDLE.
- Frame timing:
  - CS is low for exactly 2*SIZE+1 ticks.
  - SIZE rising sck edges occur.
  - Each data bit is stable one tick before its rising edge.
- Re-arm: armed<=1 in any cycle where send_enable_in=0 (checked every clk_in, not just on ticks). A held-high send_enable_in produces exactly one frame.
- Abort: if send_enable_in=0 in any cycle while busy_out=1, the next clk_in edge sets:
  - sck_out=0, cs_out_n all 1, busy_out=0, state IDLE.
  - serial_out holds its last value.
- Changes to data_in or cs_select_in mid-frame have no effect.
- cs_select_in=0 sends the frame with no CS asserted.
- Multiple select bits assert multiple CS lines.
- Reset mid-frame: the reset values apply at that edge.

Decomposition:
- Package spi_pkg: state enum (IDLE, LEAD, SHIFT, TRAIL).
- One sub-module: spi_tick_gen, the divider producing a single-cycle tick strobe (ports clk_in, reset_in, clk_count_max, tick_out).
- Shifter and CS logic stay in the top.

Test Plan:
- Reset asserted for 3 cycles -> sck_out=0, cs_out_n=1, busy_out=0, serial_out=0.
- SIZE=8, clk_count_max=1, data_in=0xA5, cs_select_in=1, send_enable_in held high:
  - MOSI sampled on the 8 sck rising edges = 1,0,1,0,0,1,0,1.
  - sck period = 4 clk_in cycles.
  - CS low for 34 clk_in cycles.
  - Only one frame is sent.
- Drop send_enable_in, re-raise it with data_in=0x3C, CS_SIZE=4, cs_select_in=4'b0100 -> only cs_out_n[2] goes low; sampled bits = 0,0,1,1,1,1,0,0.
- clk_count_max=0 with SIZE=8 -> sck period = 2 clk_in cycles; CS low for 17 cycles.
- Drop send_enable_in after the 3rd rising edge -> one cycle later sck_out=0, cs_out_n all 1, busy_out=0; no further sck edges.
- Change data_in to 0xFF mid-frame -> transmitted bits unchanged from the value latched at frame start.
